// File: rtl/cpu_hazard_scheduler_pkg.sv
// Shared CPU type definitions: register-file size and execution-unit encoding
// used by the issue scheduler and its scoreboard.
package cpu_hazard_scheduler_pkg;

  localparam int CPU_REG_COUNT = 32;
  localparam int CPU_REG_IDX_W = 5;

  typedef enum logic [1:0] {
    CPU_UNIT_ALU    = 2'd0,
    CPU_UNIT_LOAD   = 2'd1,
    CPU_UNIT_MULDIV = 2'd2,
    CPU_UNIT_RSVD   = 2'd3
  } cpu_unit_e;

  // The reserved encoding behaves exactly like a single-cycle op.
  function automatic cpu_unit_e decode_unit(input logic [1:0] raw);
    cpu_unit_e u;
    case (raw)
      2'd1:    u = CPU_UNIT_LOAD;
      2'd2:    u = CPU_UNIT_MULDIV;
      default: u = CPU_UNIT_ALU;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/cpu_hazard_scheduler_scoreboard.sv
// Pending-bit array for registers owned by multi-cycle producers, with two
// clear ports, one set port and four reads that see same-cycle clears.
module cpu_scoreboard
  import cpu_hazard_scheduler_pkg::*;
#(
  parameter int REG_COUNT = CPU_REG_COUNT
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            set_en,
  input  logic [CPU_REG_IDX_W-1:0]        set_idx,
  input  logic                            clr_a_en,
  input  logic [CPU_REG_IDX_W-1:0]        clr_a_idx,
  input  logic                            clr_b_en,
  input  logic [CPU_REG_IDX_W-1:0]        clr_b_idx,
  input  logic [3:0][CPU_REG_IDX_W-1:0]   read_idx,
  output logic [3:0]                      read_busy,
  output logic [REG_COUNT-1:0]            pending
);

  localparam logic [REG_COUNT-1:0] ONE = {{(REG_COUNT-1){1'b0}}, 1'b1};

  function automatic logic [REG_COUNT-1:0] onehot(input logic [CPU_REG_IDX_W-1:0] idx);
    return (int'(idx) < REG_COUNT) ? (ONE << idx) : '0;
  endfunction

  logic [REG_COUNT-1:0] clr_mask;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] pending_next;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_a_en) clr_mask = clr_mask | onehot(clr_a_idx);
    if (clr_b_en) clr_mask = clr_mask | onehot(clr_b_idx);
    if (set_en)   set_mask = onehot(set_idx);
    // Set is applied after clear so a new producer wins over a retiring one.
    pending_next = ((pending & ~clr_mask) | set_mask) & ~ONE;
  end

  always_comb begin
    read_busy = '0;
    for (int k = 0; k < 4; k++) begin
      read_busy[k] = (read_idx[k] != '0) && (|(pending & ~clr_mask & onehot(read_idx[k])));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_next;
  end

endmodule

// File: rtl/cpu_hazard_scheduler.sv
// Decode-side issue gate: stalls on RAW/WAW against multi-cycle producers and
// on the single mul/div unit, and counts stalled cycles.
module cpu_hazard_scheduler
  import cpu_hazard_scheduler_pkg::*;
#(
  parameter int REG_COUNT = CPU_REG_COUNT,
  parameter int CNT_W     = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_issue_valid,
  input  logic [2:0]           i_issue_have_rs,
  input  logic [4:0]           i_issue_rs1,
  input  logic [4:0]           i_issue_rs2,
  input  logic [4:0]           i_issue_rs3,
  input  logic                 i_issue_have_rd,
  input  logic [4:0]           i_issue_rd,
  input  logic [1:0]           i_issue_unit,
  input  logic                 i_flush,
  input  logic                 i_load_done,
  input  logic [4:0]           i_load_rd,
  input  logic                 i_muldiv_done,
  input  logic [4:0]           i_muldiv_rd,
  output logic                 o_stall,
  output logic                 o_issue_accept,
  output logic                 o_muldiv_busy,
  output logic [REG_COUNT-1:0] o_pending,
  output logic [CNT_W-1:0]     o_stall_cycles
);

  cpu_unit_e  unit;
  logic       multi_cycle;
  logic [3:0] read_busy;
  logic [3:0] hazard;
  logic       structural;
  logic       muldiv_busy;
  logic [CNT_W-1:0] stall_cycles;

  assign unit        = decode_unit(i_issue_unit);
  assign multi_cycle = (unit == CPU_UNIT_LOAD) || (unit == CPU_UNIT_MULDIV);

  cpu_scoreboard #(.REG_COUNT(REG_COUNT)) u_scoreboard (
    .clock     (i_clock),
    .reset_n   (i_reset_n),
    .set_en    (o_issue_accept && multi_cycle && i_issue_have_rd && (i_issue_rd != 5'd0)),
    .set_idx   (i_issue_rd),
    .clr_a_en  (i_load_done),
    .clr_a_idx (i_load_rd),
    .clr_b_en  (i_muldiv_done),
    .clr_b_idx (i_muldiv_rd),
    .read_idx  ({i_issue_rd, i_issue_rs3, i_issue_rs2, i_issue_rs1}),
    .read_busy (read_busy),
    .pending   (o_pending)
  );

  // Handshake: decode presents i_issue_valid and holds the instruction; it is
  // taken in any cycle with o_issue_accept = 1, otherwise held (o_stall) or
  // dropped (i_flush). Both outputs are combinational and never both high.
  assign hazard[2:0]    = i_issue_have_rs & read_busy[2:0];
  assign hazard[3]      = i_issue_have_rd & read_busy[3];
  assign structural     = (unit == CPU_UNIT_MULDIV) && muldiv_busy && !i_muldiv_done;
  assign o_stall        = i_issue_valid && !i_flush && ((|hazard) || structural);
  assign o_issue_accept = i_issue_valid && !i_flush && !o_stall;
  assign o_muldiv_busy  = muldiv_busy;
  assign o_stall_cycles = stall_cycles;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      muldiv_busy  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (o_issue_accept && (unit == CPU_UNIT_MULDIV)) muldiv_busy <= 1'b1;
      else if (i_muldiv_done)                          muldiv_busy <= 1'b0;
      if (o_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_hazard_scheduler.sv
// Directed-vector bench for cpu_hazard_scheduler: the driver pushes the
// hand-computed response of each cycle, a negedge monitor pops and compares.
module tb_cpu_hazard_scheduler;

  localparam int CW    = 4;
  localparam int EXP_W = 3 + 32 + CW;
  localparam logic [1:0] U_ALU = 2'd0, U_LD = 2'd1, U_MD = 2'd2, U_RSV = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  have_rs = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rs3 = '0, rd = '0;
  logic        have_rd = 1'b0;
  logic [1:0]  unit = '0;
  logic        flush = 1'b0;
  logic        load_done = 1'b0, muldiv_done = 1'b0;
  logic [4:0]  load_rd = '0, muldiv_rd = '0;
  logic        stall, accept, busy;
  logic [31:0] pending;
  logic [CW-1:0] stall_cycles;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  logic [CW-1:0]    m_cnt = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  cpu_hazard_scheduler #(.REG_COUNT(32), .CNT_W(CW)) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_issue_valid   (valid),
    .i_issue_have_rs (have_rs),
    .i_issue_rs1     (rs1),
    .i_issue_rs2     (rs2),
    .i_issue_rs3     (rs3),
    .i_issue_have_rd (have_rd),
    .i_issue_rd      (rd),
    .i_issue_unit    (unit),
    .i_flush         (flush),
    .i_load_done     (load_done),
    .i_load_rd       (load_rd),
    .i_muldiv_done   (muldiv_done),
    .i_muldiv_rd     (muldiv_rd),
    .o_stall         (stall),
    .o_issue_accept  (accept),
    .o_muldiv_busy   (busy),
    .o_pending       (pending),
    .o_stall_cycles  (stall_cycles)
  );

  // Clock/reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  // Driver: one call per cycle; expected values are those visible in that cycle.
  task automatic drive(input string nm, input logic rst, input logic v,
                       input logic [2:0] hrs, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] r3, input logic hrd, input logic [4:0] d,
                       input logic [1:0] u, input logic fl,
                       input logic ldd, input logic [4:0] ldr,
                       input logic mdd, input logic [4:0] mdr,
                       input logic es, input logic ea, input logic eb, input logic [31:0] ep);
    @(posedge clk); #1;
    rst_n = rst; valid = v; have_rs = hrs; rs1 = r1; rs2 = r2; rs3 = r3;
    have_rd = hrd; rd = d; unit = u; flush = fl;
    load_done = ldd; load_rd = ldr; muldiv_done = mdd; muldiv_rd = mdr;
    exp_q.push_back({es, ea, eb, ep, m_cnt});
    name_q.push_back(nm);
    if (!rst)                     m_cnt = '0;
    else if (es && m_cnt != '1)   m_cnt = m_cnt + 1'b1;
  endtask

  task automatic idle(input string nm, input logic ldd, input logic [4:0] ldr,
                      input logic mdd, input logic [4:0] mdr,
                      input logic eb, input logic [31:0] ep);
    drive(nm, 1, 0, 3'b000, 0, 0, 0, 0, 0, U_ALU, 0, ldd, ldr, mdd, mdr, 0, 0, eb, ep);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, "stall",   {31'd0, stall},  {31'd0, e[EXP_W-1]});
      check(nm, "accept",  {31'd0, accept}, {31'd0, e[EXP_W-2]});
      check(nm, "busy",    {31'd0, busy},   {31'd0, e[EXP_W-3]});
      check(nm, "pending", pending,         e[CW+31:CW]);
      check(nm, "stall_cycles", {{(32-CW){1'b0}}, stall_cycles}, {{(32-CW){1'b0}}, e[CW-1:0]});
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    drive("reset", 0, 0, 3'b000, 0, 0, 0, 0, 0, U_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Load-use on x5
    drive("ld_x5",     1, 1, 3'b001, 1, 0, 0, 1, 5, U_LD,  0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    drive("use_x5_a",  1, 1, 3'b001, 5, 0, 0, 1, 6, U_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 32'h20);
    drive("use_x5_b",  1, 1, 3'b001, 5, 0, 0, 1, 6, U_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 32'h20);
    drive("use_x5_d",  1, 1, 3'b001, 5, 0, 0, 1, 6, U_ALU, 0, 1, 5, 0, 0, 0, 1, 0, 32'h20);
    idle("after_ld5", 0, 0, 0, 0, 0, 32'h0);

    // Back-to-back mul/div
    drive("mul_x7",    1, 1, 3'b000, 0, 0, 0, 1, 7, U_MD,  0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    drive("mul_x9_a",  1, 1, 3'b000, 0, 0, 0, 1, 9, U_MD,  0, 0, 0, 0, 0, 1, 0, 1, 32'h80);
    drive("mul_x9_b",  1, 1, 3'b000, 0, 0, 0, 1, 9, U_MD,  0, 0, 0, 0, 0, 1, 0, 1, 32'h80);
    drive("mul_x9_d",  1, 1, 3'b000, 0, 0, 0, 1, 9, U_MD,  0, 0, 0, 1, 7, 0, 1, 1, 32'h80);
    idle("busy_hold",  0, 0, 0, 0, 1, 32'h200);
    idle("md_done9",   0, 0, 1, 9, 1, 32'h200);
    idle("md_idle",    0, 0, 0, 0, 0, 32'h0);

    // x0 never pending
    drive("ld_x0",     1, 1, 3'b000, 0, 0, 0, 1, 0, U_LD,  0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    drive("rd_x0",     1, 1, 3'b011, 0, 0, 0, 0, 0, U_ALU, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);

    // Same-cycle set and clear of x3, then WAW and flush
    drive("ld_x3_clr", 1, 1, 3'b000, 0, 0, 0, 1, 3, U_LD,  0, 1, 3, 0, 0, 0, 1, 0, 32'h0);
    idle("x3_set",     0, 0, 0, 0, 0, 32'h8);
    drive("waw_x3",    1, 1, 3'b000, 0, 0, 0, 1, 3, U_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 32'h8);
    drive("flush_x3",  1, 1, 3'b000, 0, 0, 0, 1, 3, U_ALU, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8);
    drive("flush_clr", 1, 1, 3'b000, 0, 0, 0, 1, 3, U_ALU, 1, 1, 3, 0, 0, 0, 0, 0, 32'h8);
    idle("x3_clear",   0, 0, 0, 0, 0, 32'h0);

    // Source-valid gating on rs2/rs3
    drive("ld_x12",    1, 1, 3'b000, 0, 0, 0, 1, 12, U_LD, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    drive("rs3_x12",   1, 1, 3'b100, 0, 0, 12, 0, 0, U_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1000);
    drive("rs3_nouse", 1, 1, 3'b011, 1, 2, 12, 0, 0, U_ALU, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000);
    drive("rs2_x12",   1, 1, 3'b010, 0, 12, 0, 0, 0, U_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1000);
    idle("dual_same",  1, 12, 1, 12, 0, 32'h1000);
    drive("rsv_unit",  1, 1, 3'b000, 0, 0, 0, 1, 14, U_RSV, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    idle("rsv_none",   0, 0, 0, 0, 0, 32'h0);

    // Both done strobes, different registers
    drive("ld_x20",    1, 1, 3'b000, 0, 0, 0, 1, 20, U_LD, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    drive("mul_x21",   1, 1, 3'b000, 0, 0, 0, 1, 21, U_MD, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100000);
    idle("dual_diff",  1, 20, 1, 21, 1, 32'h300000);
    idle("dual_after", 0, 0, 0, 0, 0, 32'h0);

    // Counter saturation, then reset with x4 pending
    drive("ld_x4",     1, 1, 3'b000, 0, 0, 0, 1, 4, U_LD,  0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 20; i++)
      drive("sat_stall", 1, 1, 3'b001, 4, 0, 0, 0, 0, U_ALU, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10);
    drive("rst_mid",   0, 0, 3'b000, 0, 0, 0, 0, 0, U_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10);
    idle("post_rst",   1, 4, 0, 0, 0, 32'h0);
    idle("post_rst2",  0, 0, 0, 0, 0, 32'h0);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_scheduler.md
# cpu_hazard_scheduler

Issue-gating scoreboard for the Klara-RV pipeline that sequences the operand forwarding network. It tracks destination registers owned by multi-cycle producers (loads, mul/div), stalls decode whenever a source or destination operand would read a value the forwarding network cannot yet supply, and holds the single mul/div unit busy until it retires. Sits beside the decode stage; forwarding itself stays in the existing forwarding block.

## Interface
- REG_COUNT, 32: architectural registers tracked; x0 is never pending.
- CNT_W, 32: width of the stall performance counter.

- i_clock  in  1  pipeline clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_issue_valid  in  1  decode holds an instruction requesting issue.
- i_issue_have_rs  in  3  source-operand valid bits for rs1/rs2/rs3.
- i_issue_rs1 / i_issue_rs2 / i_issue_rs3  in  5 each  source register indices.
- i_issue_have_rd  in  1  instruction writes rd.
- i_issue_rd  in  5  destination index.
- i_issue_unit  in  2  0 = single-cycle, 1 = load, 2 = mul/div, 3 = reserved (treated as 0).
- i_flush  in  1  decode instruction is squashed this cycle.
- i_load_done  in  1  memory stage returns load data this cycle.
- i_load_rd  in  5  register written by that load.
- i_muldiv_done  in  1  mul/div result valid this cycle.
- i_muldiv_rd  in  5  register written by that result.
- o_stall  out  1  decode must hold; instruction not accepted.
- o_issue_accept  out  1  instruction accepted this cycle.
- o_muldiv_busy  out  1  mul/div unit occupied.
- o_pending  out  REG_COUNT  scoreboard contents (debug).
- o_stall_cycles  out  CNT_W  saturating count of stalled cycles.

## Operation
- Scoreboard: one pending bit per register; bit 0 tied to 0.
- Hazard for operand k: have_rs[k] and rs_k != 0 and pending[rs_k] and not cleared this cycle (done with matching rd).
- WAW hazard: have_rd and rd != 0 and pending[rd] and not cleared this cycle.
- Structural hazard: unit = mul/div and o_muldiv_busy and not i_muldiv_done.
- o_stall = i_issue_valid and not i_flush and any hazard.
- o_issue_accept = i_issue_valid and not i_flush and not o_stall.
- On accept with unit load or mul/div and have_rd and rd != 0: set pending[rd]. Single-cycle ops never set pending (forwarding covers them).
- On accept with unit mul/div: set muldiv_busy (regardless of rd).
- i_load_done / i_muldiv_done clear pending of their rd; i_muldiv_done clears muldiv_busy. Both done strobes in one cycle are legal, different or equal rd.
- Same-cycle set and clear of one register: set wins.
- Done for a register not pending: ignored, no error.
- i_flush suppresses accept; already-issued producers are never cancelled and retire normally.
- o_stall_cycles increments on each cycle o_stall = 1, saturates at all ones.

## Timing
- Reset (i_reset_n low at rising edge): pending all 0, muldiv_busy 0, o_stall_cycles 0; o_stall and o_issue_accept follow inputs combinationally (0 when i_issue_valid = 0).
- Reset mid-operation discards all pending state; outstanding done strobes after reset are ignored.
- o_stall / o_issue_accept: combinational from inputs and registered state, zero latency.
- Scoreboard updates at the rising edge following accept/done; a dependent instruction in the same cycle as its producer's done strobe issues without stall (value taken from writeback forwarding).
- Load-use: load accepted cycle N, dependent stalls from N+1 until cycle of i_load_done.

## Structure
- Unit encoding enum (CPU_UNIT_ALU/LOAD/MULDIV) and REG_COUNT belong in the shared CPU_Types package.
- Natural sub-module: cpu_scoreboard (pending-bit array with set/clear ports and bypassed read of three sources plus rd); hazard logic and counter in the top.

## Test plan
- Load x5 accepted, next instruction reads rs1 = x5 -> o_stall = 1 each cycle until i_load_done rd = 5; dependent accepted that same cycle, pending[5] = 0 next cycle.
- Mul to x7 then second mul to x9 -> second stalls while busy; accepted in cycle of i_muldiv_done; busy stays 1 afterward.
- Load to x0 then reader of x0 -> no pending bit set, no stall.
- Accept load to x3 in same cycle as i_load_done rd = 3 -> pending[3] = 1 after edge (set wins).
- Stalled instruction with i_flush = 1 -> o_stall = 0, o_issue_accept = 0, counter unchanged; pending load still clears on its done.
- Preload o_stall_cycles near all ones (force CNT_W = 4, 20 stall cycles) -> counter holds 15; reset with x4 pending -> o_pending = 0 next cycle.
